// File: rtl/demo_part_sequencer.sv
// Frame-level timeline for the VGA demo: frame counter, part index and per-part
// fade envelope (fade-in, run, fade-out), all advanced once per vsync rising edge.
module demo_part_sequencer #(
  parameter int unsigned NUM_PARTS = 6,
  parameter int unsigned PART_LEN  = 128,
  parameter int unsigned FADE_STEP = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_vsync,
  input  logic        i_pause,
  input  logic        i_skip,
  output logic [11:0] o_frame_counter,
  output logic [2:0]  o_part,
  output logic [7:0]  o_part_frame,
  output logic [1:0]  o_fade,
  output logic        o_part_start,
  output logic        o_loop_done
);

  localparam int unsigned CW        = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  localparam int unsigned RUN_LAST  = PART_LEN - 3*FADE_STEP - 1;
  localparam int unsigned OUT_FRAME = PART_LEN - 3*FADE_STEP;

  typedef enum logic [1:0] {S_FADE_IN, S_RUN, S_FADE_OUT} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_fade_cnt;
  logic            r_skip_pend;
  logic            r_vsync_q;
  logic            r_skip_q;
  logic [11:0]     r_frame_counter;
  logic [2:0]      r_part;
  logic [7:0]      r_part_frame;
  logic [1:0]      r_fade;
  logic            r_part_start;
  logic            r_loop_done;

  logic w_tick;
  logic w_skip_edge;
  logic w_step;
  logic w_last_part;

  always_comb begin
    w_tick      = i_vsync & ~r_vsync_q;
    w_skip_edge = i_skip & ~r_skip_q;
    w_step      = (r_fade_cnt == CW'(FADE_STEP - 1));
    w_last_part = (r_part == 3'(NUM_PARTS - 1));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state         <= S_FADE_IN;
      r_fade_cnt      <= '0;
      r_skip_pend     <= 1'b0;
      r_vsync_q       <= 1'b0;
      r_skip_q        <= 1'b0;
      r_frame_counter <= '0;
      r_part          <= '0;
      r_part_frame    <= '0;
      r_fade          <= '0;
      r_part_start    <= 1'b0;
      r_loop_done     <= 1'b0;
    end else begin
      r_vsync_q    <= i_vsync;
      r_skip_q     <= i_skip;
      r_part_start <= 1'b0;
      r_loop_done  <= 1'b0;
      // Skip requests only matter before fade-out; a paused tick leaves them pending.
      if (r_state == S_FADE_OUT)
        r_skip_pend <= 1'b0;
      else if (w_skip_edge)
        r_skip_pend <= 1'b1;

      if (w_tick && !i_pause) begin
        r_frame_counter <= r_frame_counter + 12'd1;
        case (r_state)
          S_FADE_IN, S_RUN: begin
            if (r_skip_pend || (r_state == S_RUN && r_part_frame == 8'(RUN_LAST))) begin
              r_state      <= S_FADE_OUT;
              r_part_frame <= 8'(OUT_FRAME);
              r_fade_cnt   <= '0;
              r_skip_pend  <= 1'b0;
            end else begin
              r_part_frame <= r_part_frame + 8'd1;
              if (r_state == S_FADE_IN) begin
                if (w_step) begin
                  r_fade_cnt <= '0;
                  r_fade     <= r_fade + 2'd1;
                  if (r_fade == 2'd2) r_state <= S_RUN;
                end else begin
                  r_fade_cnt <= r_fade_cnt + CW'(1);
                end
              end
            end
          end
          S_FADE_OUT: begin
            // Part ends on the tick that reaches black, or at once if entered at black.
            if (r_fade == 2'd0 || (w_step && r_fade == 2'd1)) begin
              r_part       <= w_last_part ? 3'd0 : r_part + 3'd1;
              r_part_frame <= '0;
              r_fade_cnt   <= '0;
              r_fade       <= '0;
              r_state      <= S_FADE_IN;
              r_part_start <= 1'b1;
              r_loop_done  <= w_last_part;
            end else begin
              r_part_frame <= r_part_frame + 8'd1;
              if (w_step) begin
                r_fade_cnt <= '0;
                r_fade     <= r_fade - 2'd1;
              end else begin
                r_fade_cnt <= r_fade_cnt + CW'(1);
              end
            end
          end
          default: r_state <= S_FADE_IN;
        endcase
      end
    end
  end

  assign o_frame_counter = r_frame_counter;
  assign o_part          = r_part;
  assign o_part_frame    = r_part_frame;
  assign o_fade          = r_fade;
  assign o_part_start    = r_part_start;
  assign o_loop_done     = r_loop_done;

endmodule
